fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I pipeline, directly upstream of decode (where immediate generation and register read happen). Holds the fetch PC, drives the synchronous-read instruction memory, and presents one aligned {pc, instruction, valid} triple per cycle to decode. Supports a decode stall (lossless hold of the in-flight instruction) and a redirect from execute for taken branches and jumps, with a one-cycle bubble.

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_hold_buf.sv | 55 +++++
 rtl/fetch_stage.sv | 64 ++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I constants and payload types for the front end.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC = 32'h4000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Response register payload: the PC whose instruction is being presented.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } fetch_resp_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory, decode handshake and execute redirect.
interface fetch_stage_if;
  import rv_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_dout;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            fetch_misaligned;

  // Fetch stage side
  modport master (
    output imem_addr, if_valid, if_pc, if_inst, fetch_misaligned,
    input  imem_dout, stall, redirect_valid, redirect_pc
  );

  // Surrounding pipeline / memory side
  modport slave (
    input  imem_addr, if_valid, if_pc, if_inst, fetch_misaligned,
    output imem_dout, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// Captures the memory word on the first stall cycle so the presented
// instruction stays stable while imem_dout moves on to the next address.
module fetch_hold_buf
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            resp_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] imem_dout,
  output logic [XLEN-1:0] inst_c
);

  logic            hold_valid, hold_valid_nxt;
  logic [XLEN-1:0] hold_inst, hold_inst_nxt;

  // Next-state: flush drops the word, first stall cycle captures, advance releases
  always_comb begin
    hold_valid_nxt = hold_valid;
    hold_inst_nxt  = hold_inst;
    if (flush) begin
      hold_valid_nxt = 1'b0;
    end else if (stall) begin
      if (resp_valid && !hold_valid) begin
        hold_valid_nxt = 1'b1;
        hold_inst_nxt  = imem_dout;
      end
    end else begin
      hold_valid_nxt = 1'b0;
    end
  end

  // Hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_inst  <= '0;
    end else begin
      hold_valid <= hold_valid_nxt;
      hold_inst  <= hold_inst_nxt;
    end
  end

  // Presented instruction: NOP in a bubble, held word while stalled, else live memory data
  always_comb begin
    inst_c = imem_dout;
    if (!resp_valid) begin
      inst_c = NOP_INST;
    end else if (hold_valid) begin
      inst_c = hold_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: fetch PC, synchronous imem addressing, decode
// stall with lossless hold, and execute redirect with a one-cycle bubble.
module fetch_stage
  import rv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  fetch_resp_t     resp, resp_nxt;
  logic            fetch_misaligned, fetch_misaligned_nxt;
  logic [XLEN-1:0] inst_c;

  // Next-state: redirect beats stall, stall beats advance
  always_comb begin
    fetch_pc_nxt         = fetch_pc;
    resp_nxt             = resp;
    fetch_misaligned_nxt = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_nxt         = {bus.redirect_pc[XLEN-1:2], 2'b00};
      resp_nxt.valid       = 1'b0;
      fetch_misaligned_nxt = |bus.redirect_pc[1:0];
    end else if (!bus.stall) begin
      resp_nxt.valid = 1'b1;
      resp_nxt.pc    = fetch_pc;
      fetch_pc_nxt   = fetch_pc + PC_STEP;
    end
  end

  // PC and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc         <= RESET_PC;
      resp.valid       <= 1'b0;
      resp.pc          <= RESET_PC;
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_pc         <= fetch_pc_nxt;
      resp             <= resp_nxt;
      fetch_misaligned <= fetch_misaligned_nxt;
    end
  end

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .resp_valid (resp.valid),
    .stall      (bus.stall),
    .flush      (bus.redirect_valid),
    .imem_dout  (bus.imem_dout),
    .inst_c     (inst_c)
  );

  assign bus.imem_addr        = fetch_pc;
  assign bus.if_valid         = resp.valid;
  assign bus.if_pc            = resp.pc;
  assign bus.if_inst          = inst_c;
  assign bus.fetch_misaligned = fetch_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, corner sequences, randomized run
// against a reference model of the presented instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word k above the BIOS base holds k
  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] d;
    d = a - RST_PC;
    return d >> 2;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) bus.imem_dout <= memf(bus.imem_addr);

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Reference model: what decode should see, and the next address to be presented
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic        m_mis;

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = RST_PC;
    m_next  = RST_PC;
    m_mis   = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] rp);
    m_mis = 1'b0;
    if (rv) begin
      m_valid = 1'b0;
      m_next  = {rp[31:2], 2'b00};
      m_mis   = (rp[1:0] != 2'b00);
    end else if (!s) begin
      m_valid = 1'b1;
      m_pc    = m_next;
      m_next  = m_next + 32'd4;
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge happen, return at next falling edge
  task automatic step(input logic s, input logic rv, input logic [31:0] rp);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    @(posedge clk);
    model_edge(s, rv, rp);
    @(negedge clk);
  endtask

  task automatic check_model(input int idx);
    cmp("m_valid", idx, 32'(bus.if_valid), 32'(m_valid));
    cmp("m_pc",    idx, bus.if_pc, m_pc);
    cmp("m_inst",  idx, bus.if_inst, m_valid ? memf(m_pc) : NOP);
    cmp("m_mis",   idx, 32'(bus.fetch_misaligned), 32'(m_mis));
    cmp("m_addr",  idx, bus.imem_addr, m_next);
  endtask

  typedef struct {
    logic        s;
    logic        rv;
    logic [31:0] rp;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        emis;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rp,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic emis);
    vec_t v;
    v.s = s; v.rv = rv; v.rp = rp; v.ev = ev; v.epc = epc; v.einst = einst; v.emis = emis;
    return v;
  endfunction

  initial begin
    // Stream from reset, stall, redirects, misaligned target, wrap, stall in bubble
    vt[0]  = mk(0, 0, 0,            1, 32'h4000_0000, 32'd0, 0);
    vt[1]  = mk(0, 0, 0,            1, 32'h4000_0004, 32'd1, 0);
    vt[2]  = mk(0, 0, 0,            1, 32'h4000_0008, 32'd2, 0);
    vt[3]  = mk(1, 0, 0,            1, 32'h4000_0008, 32'd2, 0);
    vt[4]  = mk(1, 0, 0,            1, 32'h4000_0008, 32'd2, 0);
    vt[5]  = mk(1, 0, 0,            1, 32'h4000_0008, 32'd2, 0);
    vt[6]  = mk(0, 0, 0,            1, 32'h4000_000C, 32'd3, 0);
    vt[7]  = mk(0, 0, 0,            1, 32'h4000_0010, 32'd4, 0);
    vt[8]  = mk(0, 1, 32'h4000_0100, 0, 32'h4000_0010, NOP, 0);
    vt[9]  = mk(0, 0, 0,            1, 32'h4000_0100, 32'h40, 0);
    vt[10] = mk(0, 0, 0,            1, 32'h4000_0104, 32'h41, 0);
    vt[11] = mk(1, 0, 0,            1, 32'h4000_0104, 32'h41, 0);
    vt[12] = mk(1, 1, 32'h4000_0200, 0, 32'h4000_0104, NOP, 0);
    vt[13] = mk(0, 0, 0,            1, 32'h4000_0200, 32'h80, 0);
    vt[14] = mk(0, 1, 32'h4000_0102, 0, 32'h4000_0200, NOP, 1);
    vt[15] = mk(0, 0, 0,            1, 32'h4000_0100, 32'h40, 0);
    vt[16] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h4000_0100, NOP, 0);
    vt[17] = mk(0, 0, 0,            1, 32'hFFFF_FFFC, 32'h2FFF_FFFF, 0);
    vt[18] = mk(0, 0, 0,            1, 32'h0000_0000, 32'h3000_0000, 0);
    vt[19] = mk(0, 0, 0,            1, 32'h0000_0004, 32'h3000_0001, 0);
    vt[20] = mk(0, 1, 32'h4000_0000, 0, 32'h0000_0004, NOP, 0);
    vt[21] = mk(1, 0, 0,            0, 32'h0000_0004, NOP, 0);
    vt[22] = mk(0, 0, 0,            1, 32'h4000_0000, 32'd0, 0);

    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Outputs while held in reset
    cmp("rst_valid", 0, 32'(bus.if_valid), 32'd0);
    cmp("rst_pc",    0, bus.if_pc, RST_PC);
    cmp("rst_inst",  0, bus.if_inst, NOP);
    cmp("rst_addr",  0, bus.imem_addr, RST_PC);
    cmp("rst_mis",   0, 32'(bus.fetch_misaligned), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vt[i].s, vt[i].rv, vt[i].rp);
      cmp("tbl_valid", i, 32'(bus.if_valid), 32'(vt[i].ev));
      cmp("tbl_pc",    i, bus.if_pc, vt[i].epc);
      cmp("tbl_inst",  i, bus.if_inst, vt[i].einst);
      cmp("tbl_mis",   i, 32'(bus.fetch_misaligned), 32'(vt[i].emis));
    end

    // Reset pulsed mid-stall: outputs clear with no clock edge
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    cmp("stall_pre_rst", 0, 32'(bus.if_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_valid", 0, 32'(bus.if_valid), 32'd0);
    cmp("async_inst",  0, bus.if_inst, NOP);
    cmp("async_pc",    0, bus.if_pc, RST_PC);
    cmp("async_addr",  0, bus.imem_addr, RST_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    check_model(1000);
    step(0, 0, 0);
    cmp("restart_pc",   0, bus.if_pc, RST_PC);
    cmp("restart_inst", 0, bus.if_inst, 32'd0);
    step(0, 0, 0);
    cmp("restart_pc",   1, bus.if_pc, RST_PC + 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        s, rv;
      logic [31:0] rp;
      s  = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0)
        rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        rp = RST_PC + 32'($urandom_range(0, 1023));
      step(s, rv, rp);
      check_model(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
